// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the fetch stage.
package pipeline_pkg;

  localparam logic [31:0] RESET_PC_C  = 32'h8000_0000;
  localparam logic [31:0] IRQ_VEC_C   = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC_C   = 32'h8000_0008;
  localparam logic [31:0] NOP_C       = 32'h0000_0000;
  localparam logic [31:0] SUPER_BIT_C = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  typedef enum logic [2:0] {
    NPC_SEQ,
    NPC_HOLD,
    NPC_JR,
    NPC_BR,
    NPC_JMP,
    NPC_IRQ,
    NPC_EXC
  } npc_kind_e;

  // Supervisor bit rides along; low 31 bits wrap.
  function automatic logic [31:0] pc_inc(
    input logic [31:0] pc
  );
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/if_stage_next_pc_sel.sv
// Next-PC priority mux for the fetch stage.
// Build option IF_SUPERVISOR_MASK_EN forces PC[31] on vectors.
module next_pc_sel
  import pipeline_pkg::*;
#(
  parameter logic [31:0] IRQ_VEC = IRQ_VEC_C,
  parameter logic [31:0] EXC_VEC = EXC_VEC_C
) (
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        exc,
  input  logic        irq_ok,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] pc_seq,
  output logic [31:0] npc,
  output npc_kind_e   kind
);

  logic [31:0] irq_vec;
  logic [31:0] exc_vec;

`ifdef IF_SUPERVISOR_MASK_EN
  assign irq_vec = IRQ_VEC | SUPER_BIT_C;
  assign exc_vec = EXC_VEC | SUPER_BIT_C;
`else
  assign irq_vec = IRQ_VEC;
  assign exc_vec = EXC_VEC;
`endif

  assign pc_seq = pc_inc(pc);

  // Vectors outrank stall; redirects under stall are dropped.
  always_comb begin
    kind = NPC_SEQ;
    if (exc)
      kind = NPC_EXC;
    else if (irq_ok)
      kind = NPC_IRQ;
    else if (stall)
      kind = NPC_HOLD;
    else if (jr)
      kind = NPC_JR;
    else if (branch)
      kind = NPC_BR;
    else if (jump)
      kind = NPC_JMP;
  end

  always_comb begin
    npc = pc_seq;
    unique case (kind)
      NPC_EXC:  npc = exc_vec;
      NPC_IRQ:  npc = irq_vec;
      NPC_HOLD: npc = pc;
      NPC_JR:   npc = jr_target;
      NPC_BR:   npc = branch_target;
      NPC_JMP:  npc = jump_target;
      default:  npc = pc_seq;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, next-PC select, IF/ID register, EPC.
// Build option IF_SUPERVISOR_MASK_EN masks irq while PC[31]=1.
module if_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_C,
  parameter logic [31:0] IRQ_VEC  = IRQ_VEC_C,
  parameter logic [31:0] EXC_VEC  = EXC_VEC_C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        jr_i,
  input  logic [31:0] jr_target_i,
  input  logic        irq_i,
  input  logic        exc_i,
  input  logic [31:0] exc_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  output logic [31:0] if_id_instr_o,
  output logic [31:0] if_id_pc4_o,
  output logic        if_id_valid_o,
  output logic [31:0] epc_o,
  output logic        irq_taken_o
);

  logic [31:0] pc;
  logic [31:0] npc;
  logic [31:0] pc_seq;
  logic [31:0] epc;
  logic        irq_taken_q;
  logic        irq_ok;
  logic        bubble;
  npc_kind_e   kind;
  if_id_t      if_id;

`ifdef IF_SUPERVISOR_MASK_EN
  assign irq_ok = irq_i & ~pc[31] & ~exc_i;
`else
  // History flop spaces acceptances at least two cycles apart.
  assign irq_ok = irq_i & ~exc_i & ~irq_taken_q;
`endif

  assign bubble = exc_i | irq_ok | flush_i;

  next_pc_sel #(
    .IRQ_VEC(IRQ_VEC),
    .EXC_VEC(EXC_VEC)
  ) u_sel (
    .pc           (pc),
    .stall        (stall_i),
    .exc          (exc_i),
    .irq_ok       (irq_ok),
    .jr           (jr_i),
    .jr_target    (jr_target_i),
    .branch       (branch_i),
    .branch_target(branch_target_i),
    .jump         (jump_i),
    .jump_target  (jump_target_i),
    .pc_seq       (pc_seq),
    .npc          (npc),
    .kind         (kind)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc          <= RESET_PC;
      epc         <= 32'h0;
      irq_taken_q <= 1'b0;
    end else begin
      pc          <= npc;
      irq_taken_q <= irq_ok;
      if (kind == NPC_EXC)
        epc <= exc_pc_i;
      else if (kind == NPC_IRQ)
        epc <= pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if_id <= '{instr: NOP_C, pc4: 32'h0, valid: 1'b0};
    end else if (bubble) begin
      if_id <= '{instr: NOP_C, pc4: 32'h0, valid: 1'b0};
    end else if (!stall_i) begin
      if_id <= '{instr: imem_instr_i, pc4: pc_seq, valid: 1'b1};
    end
  end

  assign imem_addr_o   = pc;
  assign if_id_instr_o = if_id.instr;
  assign if_id_pc4_o   = if_id.pc4;
  assign if_id_valid_o = if_id.valid;
  assign epc_o         = epc;
  assign irq_taken_o   = irq_taken_q;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the program counter and next-PC selection.
- Drives the instruction-memory address and captures the returned instruction into the IF/ID pipeline register.
- Handles stall, flush, branch/jump/jr redirects, and interrupt/exception vectoring with a PC[31] supervisor bit.

Parameters:
- RESET_PC, 32'h80000000, PC value loaded on reset.
- IRQ_VEC, 32'h80000004, interrupt handler entry.
- EXC_VEC, 32'h80000008, exception handler entry.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- stall_i  in  1  load-use hazard; hold PC and IF/ID.
- flush_i  in  1  squash IF/ID (wrong-path fetch).
- branch_i  in  1  taken branch redirect.
- branch_target_i  in  32  branch target.
- jump_i  in  1  j/jal redirect.
- jump_target_i  in  32  {pc[31:28], index, 2'b00}, formed upstream.
- jr_i  in  1  jr/jalr redirect.
- jr_target_i  in  32  register target; may clear PC[31].
- irq_i  in  1  level interrupt request from timer/peripheral.
- exc_i  in  1  one-cycle exception pulse.
- exc_pc_i  in  32  PC of the faulting instruction.
- imem_addr_o  out  32  combinational copy of PC register.
- imem_instr_i  in  32  instruction returned combinationally by instruction memory.
- if_id_instr_o  out  32  registered instruction.
- if_id_pc4_o  out  32  registered PC+4 of that instruction.
- if_id_valid_o  out  1  0 = bubble.
- epc_o  out  32  saved return PC for the handler ($26 source).
- irq_taken_o  out  1  one-cycle pulse when an interrupt is accepted.

Behaviour:
- Reset (reset==0 at edge):
  - pc=RESET_PC.
  - if_id_instr_o=32'h0, if_id_pc4_o=32'h0, if_id_valid_o=0.
  - epc_o=32'h0, irq_taken_o=0.
  - Reset mid-operation discards any pending redirect.
- PC+4 preserves the supervisor bit: pc_seq = {pc[31], pc[30:0]+31'd4}. Bits 30:2 wrap silently.
- Interrupt acceptance: irq_ok = irq_i & ~pc[31] & ~exc_i.
- Next-PC priority, highest first:
  - reset
  - exc_i -> EXC_VEC; epc_o<=exc_pc_i
  - irq_ok -> IRQ_VEC; epc_o<=pc (interrupted, not yet issued); irq_taken_o=1
  - stall_i -> hold pc
  - jr_i -> jr_target_i
  - branch_i -> branch_target_i
  - jump_i -> jump_target_i
  - otherwise pc_seq
- exc/irq override stall. A redirect concurrent with stall is dropped; the redirecting instruction is held in ID and re-asserts next cycle.
- IF/ID update, in priority order:
  - exc_i, irq_ok or flush_i -> bubble: instr=0, pc4=0, valid=0. Applies even if stall_i.
  - else stall_i -> hold all three.
  - else load imem_instr_i, pc_seq, valid=1.
- Latency: one cycle from imem_addr_o to if_id_instr_o. Straight-line code gives one instruction per cycle.
- irq_i held high while pc[31]=1 is ignored until a jr clears pc[31].
- epc_o changes only on exc/irq acceptance.

Optional Feature:
- Macro: IF_SUPERVISOR_MASK_EN.
- Defined:
  - irq masked while pc[31]=1, as above.
  - EXC_VEC/IRQ_VEC force pc[31]=1.
- Undefined:
  - irq_ok = irq_i & ~exc_i & ~irq_taken_q.
  - irq_taken_q is a one-cycle history flop, so acceptance happens at most every other cycle.
  - pc[31] is carried as an ordinary address bit with no masking.
- All other behaviour is identical in both builds.

Decomposition:
- Package pipeline_pkg holds:
  - constants RESET_PC_C, IRQ_VEC_C, EXC_VEC_C, NOP_C=32'h0
  - typedef if_id_t {instr, pc4, valid}
- Sub-module next_pc_sel: combinational priority mux producing next pc and redirect-kind flags.
- if_stage keeps all registers.

Test Plan:
1. Release reset, no events for 3 cycles -> imem_addr_o 80000000, 80000004, 80000008. Cycle 2 shows if_id_pc4_o=80000004, valid=1.
2. At pc=0000000C assert stall_i 2 cycles, then jump_i with target 00000040 -> pc holds 0C for both stall cycles; jump dropped while stalled; once jump re-asserts after the stall, next pc=00000040.
3. pc=00000020, branch_i=1, flush_i=1, target 00000010 -> pc=00000010; IF/ID instr=0, valid=0; fetch at 10 then valid.
4. pc=00000030, irq_i=1 -> pc=80000004, epc_o=00000030, irq_taken_o pulses once, IF/ID bubble. irq held high in kernel is ignored. jr_i to 00000030 resumes; irq is then re-accepted if still high.
5. exc_i=1 with irq_i=1 and stall_i=1, exc_pc_i=00000054 -> pc=80000008, epc_o=00000054, no irq_taken_o.
6. reset low during a jr_i cycle -> pc=80000000, all IF/ID outputs 0, epc_o=0.
